// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared types and constants for the bit-serial adder/subtractor.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN (adds the signed-overflow output).
package serial_addsub_pkg;

  localparam int SERIAL_ADDSUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// fa_cell: one-bit full adder, the only arithmetic element of the serial datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  // Sum and majority carry of the three input bits
  always_comb begin
    s  = a ^ b ^ cin;
    co = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, one result bit per clock, LSB first.
// Subtraction is A + ~B + 1: B is inverted on capture and the carry is seeded with 1.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN adds output ovf (signed overflow).
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDSUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ready,
  output logic             sum_bit,
  output logic             sum_bit_vld,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-2:0] part;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] next_res;

  // Single shared full adder working on the current operand LSBs and carry
  fa_cell u_fa (
    .a   (a_reg[0]),
    .b   (b_reg[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  // Status outputs decoded from the registered state; the serial bit is gated to RUN
  always_comb begin
    ready       = (state == IDLE);
    sum_bit_vld = (state == RUN);
    sum_bit     = (state == RUN) ? fa_s : 1'b0;
    next_res    = {fa_s, part};
  end

  // Control FSM and serial datapath; results are published only when entering DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      part  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= in_a;
            b_reg <= in_b ^ {WIDTH{sub}};
            carry <= sub;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          carry <= fa_co;
          part  <= next_res[WIDTH-1:1];
          count <= count + CW'(1);
          if (count == LAST_COUNT) begin
            state <= DONE;
            sum   <= next_res;
            cout  <= fa_co;
            done  <= 1'b1;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf   <= carry ^ fa_co;
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8 (legal 2..64), the operand/result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, the operation request, sampled only when ready=1.
REQ-005 The block SHALL have port sub, input, 1: 0 = add, 1 = subtract (A-B), sampled with start.
REQ-006 The block SHALL have ports in_a and in_b, input, WIDTH each, the parallel operands, sampled with start.
REQ-007 The block SHALL have port ready, output, 1: high only in IDLE.
REQ-008 The block SHALL have port sum_bit, output, 1, the serial result bit, LSB first.
REQ-009 The block SHALL have port sum_bit_vld, output, 1: high in every RUN cycle in which sum_bit is valid.
REQ-010 The block SHALL have port sum, output, WIDTH, the parallel result, held until the next accepted start.
REQ-011 The block SHALL have port cout, output, 1, the final carry; for subtract, 1 means no borrow.
REQ-012 The block SHALL have port done, output, 1, a single-cycle completion pulse.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the block SHALL capture in_a, and in_b XOR {WIDTH{sub}}, into shift registers, set carry=sub and bit count=0, and go to RUN.
REQ-015 In IDLE with start=0, the block SHALL leave all registers unchanged.
REQ-016 In each RUN cycle, sum_bit SHALL equal a[0]^b[0]^carry, combinational from registered state, with sum_bit_vld=1.
REQ-017 On each RUN edge: carry <= majority(a[0],b[0],carry); operands shift right by one; sum_bit shifts into the result MSB and the result shifts right; count increments.
REQ-018 After exactly WIDTH RUN edges, the block SHALL enter DONE, with sum holding the complete result and cout the final carry.
REQ-019 Latency: with start accepted at edge n, done SHALL be 1 from edge n+WIDTH to edge n+WIDTH+1, and ready SHALL return to 1 at edge n+WIDTH+1.
REQ-020 DONE SHALL last exactly one cycle and then go unconditionally to IDLE.
REQ-021 start SHALL be ignored in RUN and DONE, and the operands SHALL NOT be altered.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; sum is (in_a+in_b) or (in_a-in_b) truncated to WIDTH bits.
REQ-023 sum and cout SHALL update only on entering DONE; during RUN they hold the previous result.

Reset
REQ-024 With rst_n=0 at a clk edge, state SHALL go to IDLE, and all of the following SHALL be 0: sum, cout, done, carry, count, operand registers and (if present) ovf.
REQ-025 After reset, ready SHALL be 1, and sum_bit_vld and sum_bit SHALL be 0.
REQ-026 Reset mid-RUN or in DONE SHALL abort the operation with no done pulse; the next start SHALL behave as after power-up reset.

Configuration
REQ-027 With macro SERIAL_ADDSUB_OVF_EN defined, the block SHALL provide output ovf (1 bit), the signed two's-complement overflow.
REQ-028 ovf SHALL equal carry-into-MSB XOR cout, SHALL be registered on entering DONE and held like sum, and SHALL reset to 0.
REQ-029 Without SERIAL_ADDSUB_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 The shared package serial_addsub_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the constant SERIAL_ADDSUB_WIDTH_DEF=8.
REQ-031 The one-bit full adder SHALL be a sub-module fa_cell (a, b, cin -> s, co), instantiated once and reused every cycle.
REQ-032 The count register SHALL be $clog2(WIDTH+1) bits.

Verification (WIDTH=8)
REQ-033 Add test: in_a=0x5A, in_b=0x3C, sub=0 -> sum=0x96, cout=0, ovf=1; done exactly 8 edges after start.
REQ-034 Subtract test: in_a=0x10, in_b=0x20, sub=1 -> sum=0xF0, cout=0, ovf=0; in_a=0x20, in_b=0x10 -> sum=0x10, cout=1.
REQ-035 Wrap test: in_a=0xFF, in_b=0x01, add -> sum=0x00, cout=1, ovf=0; sum_bit stream LSB-first 0,0,0,0,0,0,0,0 with sum_bit_vld high for 8 cycles.
REQ-036 Ignored-start test: start pulsed in cycle 3 of RUN with different operands -> first result unchanged, a single done pulse, ready low throughout.
REQ-037 Mid-RUN reset test: rst_n=0 in cycle 4 -> no done, sum=0, ready=1; a following 0x01+0x01 -> sum=0x02.
REQ-038 Back-to-back test: start held high continuously -> a new operation is accepted every WIDTH+2 edges, and sum is held between the done pulses.
